// File: rtl/regfile_param.sv
// Parametrised integer register file with x0 hardwired to zero, optional write-to-read
// bypass and a one-entry-per-cycle scrub engine for re-initialisation without reset.
module regfile_param #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rs_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  input  logic [AW-1:0]            w_add,
  input  logic                     RegWrite,
  input  logic [XLEN-1:0]          RegWriteData,
  input  logic                     clear_req,
  output logic                     busy,
  output logic                     wr_accepted
);

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_ptr;
  logic [XLEN-1:0] r_mem [DEPTH];
  logic            r_busy;
  logic            r_wrAccepted;

  logic            w_wrEn;
  logic            w_scrubLast;

  // Writes are only honoured while idle; during a scrub upstream must stall on busy.
  assign w_wrEn      = RegWrite && (w_add != '0) && (r_state == IDLE);
  assign w_scrubLast = (r_ptr == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_busy       <= 1'b0;
      r_wrAccepted <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_wrAccepted <= w_wrEn;
      if (w_wrEn) begin
        r_mem[w_add] <= RegWriteData;
      end
      case (r_state)
        IDLE: begin
          // Entry 0 is never stored, so the scrub starts at entry 1.
          if (clear_req) begin
            r_state <= SCRUB;
            r_ptr   <= AW'(1);
            r_busy  <= 1'b1;
          end
        end
        SCRUB: begin
          r_mem[r_ptr] <= '0;
          if (w_scrubLast) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic            w_hit;
    logic [XLEN-1:0] w_port;

    assign w_addr = rs_addr[k*AW +: AW];
    assign w_hit  = (BYPASS != 0) && w_wrEn && (w_add == w_addr);
    assign w_port = (!rst || (w_addr == '0)) ? '0 :
                    w_hit                    ? RegWriteData :
                                               r_mem[w_addr];
    assign rd_data[k*XLEN +: XLEN] = w_port;
  end

  assign busy        = r_busy;
  assign wr_accepted = r_wrAccepted;

endmodule

// File: tb/tb_regfile_param.sv
// Drives a 32x32/2-port bypassed file and a 64x64/3-port unbypassed file with shared stimulus;
// an array-based model queues expected outputs that a negedge monitor compares.
module tb_regfile_param;

  typedef struct packed {
    logic [2:0][63:0] rd;
    logic             busy;
    logic             acc;
  } exp_t;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic [5:0]  rAddr0   = '0;
  logic [5:0]  rAddr1   = '0;
  logic [5:0]  rAddr2   = '0;
  logic [5:0]  wAdd     = '0;
  logic        regWrite = 1'b0;
  logic        clearReq = 1'b0;
  logic [63:0] wData    = '0;

  logic [9:0]   rsA;
  logic [17:0]  rsB;
  logic [63:0]  rdA;
  logic [191:0] rdB;
  logic         busyA, accA, busyB, accB;

  int checkCount = 0;
  int passCount  = 0;

  logic [63:0] mMem   [2][64];
  bit          mScrub [2];
  int          mPtr   [2];
  bit          mAcc   [2];
  exp_t        q0 [$];
  exp_t        q1 [$];

  assign rsA = {rAddr1[4:0], rAddr0[4:0]};
  assign rsB = {rAddr2, rAddr1, rAddr0};

  always #5 clk = ~clk;

  regfile_param #(.XLEN(32), .DEPTH(32), .AW(5), .NUM_RD(2), .BYPASS(1)) dutA (
    .clk(clk), .rst(rst), .rs_addr(rsA), .rd_data(rdA), .w_add(wAdd[4:0]),
    .RegWrite(regWrite), .RegWriteData(wData[31:0]), .clear_req(clearReq),
    .busy(busyA), .wr_accepted(accA)
  );

  regfile_param #(.XLEN(64), .DEPTH(64), .AW(6), .NUM_RD(3), .BYPASS(0)) dutB (
    .clk(clk), .rst(rst), .rs_addr(rsB), .rd_data(rdB), .w_add(wAdd),
    .RegWrite(regWrite), .RegWriteData(wData), .clear_req(clearReq),
    .busy(busyB), .wr_accepted(accB)
  );

  task automatic checkOutput(input string name, input int d, input logic [63:0] act,
                             input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s dut%0d: got %h, expected %h at %0t", name, d, act, exp, $time);
  endtask

  // One cycle: drive inputs, queue what both files must show now, then advance the model.
  task automatic applyStimulus(input bit r, input int a0, input int a1, input int a2,
                               input bit we, input int wa, input logic [63:0] wd,
                               input bit clr);
    exp_t e;
    int   addr [3];
    rst = r; rAddr0 = 6'(a0); rAddr1 = 6'(a1); rAddr2 = 6'(a2);
    regWrite = we; wAdd = 6'(wa); wData = wd; clearReq = clr;
    addr[0] = a0; addr[1] = a1; addr[2] = a2;
    for (int d = 0; d < 2; d++) begin
      int          depth = (d == 0) ? 32 : 64;
      int          nrd   = (d == 0) ? 2 : 3;
      bit          byp   = (d == 0);
      int          wad   = wa % depth;
      logic [63:0] mask  = (d == 0) ? 64'h0000_0000_FFFF_FFFF : '1;
      e.busy = mScrub[d];
      e.acc  = mAcc[d];
      for (int k = 0; k < 3; k++) begin
        int ra = addr[k] % depth;
        if (k >= nrd || !r || ra == 0) e.rd[k] = '0;
        else if (byp && we && wad == ra && !mScrub[d]) e.rd[k] = wd & mask;
        else e.rd[k] = mMem[d][ra];
      end
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      int          depth = (d == 0) ? 32 : 64;
      int          wad   = wa % depth;
      logic [63:0] mask  = (d == 0) ? 64'h0000_0000_FFFF_FFFF : '1;
      bit          commit;
      if (!r) begin
        for (int i = 0; i < 64; i++) mMem[d][i] = '0;
        mScrub[d] = 0; mPtr[d] = 0; mAcc[d] = 0;
      end else begin
        commit  = we && wad != 0 && !mScrub[d];
        mAcc[d] = commit;
        if (commit) mMem[d][wad] = wd & mask;
        if (mScrub[d]) begin
          mMem[d][mPtr[d]] = '0;
          if (mPtr[d] == depth - 1) mScrub[d] = 0;
          else mPtr[d]++;
        end else if (clr) begin
          mScrub[d] = 1;
          mPtr[d]   = 1;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int a0, input int a1, input int a2);
    applyStimulus(1, a0, a1, a2, 0, 0, 64'h0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() != 0) begin
      e = q0.pop_front();
      checkOutput("rd_port0", 0, {32'h0, rdA[31:0]}, e.rd[0]);
      checkOutput("rd_port1", 0, {32'h0, rdA[63:32]}, e.rd[1]);
      checkOutput("busy", 0, {63'h0, busyA}, {63'h0, e.busy});
      checkOutput("wr_accepted", 0, {63'h0, accA}, {63'h0, e.acc});
    end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      checkOutput("rd_port0", 1, rdB[63:0], e.rd[0]);
      checkOutput("rd_port1", 1, rdB[127:64], e.rd[1]);
      checkOutput("rd_port2", 1, rdB[191:128], e.rd[2]);
      checkOutput("busy", 1, {63'h0, busyB}, {63'h0, e.busy});
      checkOutput("wr_accepted", 1, {63'h0, accB}, {63'h0, e.acc});
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) mMem[d][i] = '0;
      mScrub[d] = 0; mPtr[d] = 0; mAcc[d] = 0;
    end
    @(posedge clk);
    #1;

    $display("[TB] reset zeroing");
    applyStimulus(0, 5, 3, 5, 0, 0, 64'h0, 0);
    applyStimulus(0, 5, 3, 5, 0, 0, 64'h0, 0);
    for (int i = 0; i < 64; i++) idle(i, i ^ 1, 63 - i);

    $display("[TB] write, readback and bypass");
    applyStimulus(1, 7, 7, 7, 1, 7, 64'hCAFEF00D_DEADBEEF, 0);
    idle(7, 7, 7);
    applyStimulus(1, 63, 63, 63, 1, 63, 64'h0123_4567_89AB_CDEF, 0);
    idle(63, 63, 63);

    $display("[TB] x0 protection");
    applyStimulus(1, 0, 0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    idle(0, 0, 0);

    $display("[TB] scrub with late write and repeated clear_req");
    for (int i = 1; i < 64; i++) applyStimulus(1, i, 0, i, 1, i, 64'(i), 0);
    for (int i = 1; i < 32; i++) applyStimulus(1, i, 11, i, 1, i, 64'(i), 0);
    applyStimulus(1, 1, 11, 2, 0, 0, 64'h0, 1);
    for (int c = 0; c < 70; c++) begin
      if (c == 3) applyStimulus(1, 4, 11, 4, 1, 4, 64'd99, 0);
      else if (c == 5) applyStimulus(1, c, 11, c + 1, 0, 0, 64'h0, 1);
      else idle(c % 64, 11, (c + 1) % 64);
    end
    for (int i = 0; i < 64; i++) idle(i, 4, 63 - i);

    $display("[TB] clear_req together with a write");
    applyStimulus(1, 9, 9, 9, 1, 9, 64'd55, 1);
    for (int c = 0; c < 66; c++) idle(9, c % 64, 9);

    $display("[TB] reset mid-scrub");
    for (int i = 1; i < 64; i++) applyStimulus(1, i, i, i, 1, i, 64'(i * 3), 0);
    applyStimulus(1, 20, 40, 50, 0, 0, 64'h0, 1);
    for (int c = 0; c < 12; c++) idle(20, 40, 50);
    applyStimulus(0, 20, 40, 50, 0, 0, 64'h0, 0);
    for (int i = 0; i < 64; i++) idle(i, 63 - i, i);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      bit          r   = ($urandom_range(0, 299) != 0);
      bit          we  = ($urandom_range(0, 1) == 1);
      bit          clr = ($urandom_range(0, 199) == 0);
      int          wa  = $urandom_range(0, 63);
      logic [63:0] wd  = {$urandom, $urandom};
      int          a0  = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 63);
      int          a1  = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 63);
      int          a2  = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 63);
      applyStimulus(r, a0, a1, a2, we, wa, wd, clr);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
